mcm_dsp_scheduler: RTL

Time-multiplexing scheduler that shares one DSP48E1-based constant-multiplier slice among `N_REQ` requesters. Each requester owns one constant; the scheduler arbitrates round-robin, drives the operand and constant-select into the DSP wrapper, and tracks in-flight operations through the DSP's registered P stage. It returns each product with its requester ID through a credit-protected result buffer, so backpressure never drops a DSP result. The block sits between requester logic and a `dsp_sel`-muxed multiplier wrapper built from `mblock`-style DSP instances.

---
 rtl/mcm_pkg.sv | 24 ++
 rtl/mcm_res_fifo.sv | 55 +++++
 rtl/mcm_dsp_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mcm_pkg.sv
// Shared definitions for the multiple-constant-multiplier scheduler: default widths,
// the ID width helper, the result record and the per-requester constant table.
package mcm_pkg;

  localparam int unsigned X_W_DEF   = 8;
  localparam int unsigned OUT_W_DEF = 35;
  localparam int unsigned MAX_REQ   = 16;

  // Constant owned by each requester; the DSP wrapper selects one with dsp_sel.
  localparam int MCM_CONST [MAX_REQ] = '{
    12345, -3001, 86746874, 1000003, 77, -5, 1234567, -98765,
    31, 4096, -65536, 7777777, 3, -1, 555555, 24680
  };

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [3:0]                  id;
    logic signed [OUT_W_DEF-1:0] data;
  } mcm_res_t;

endpackage

// File: rtl/mcm_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count; the head word reads as
// zero while empty so no stale data is visible after reset.
module mcm_res_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcm_dsp_scheduler.sv
// Round-robin scheduler sharing one constant-multiplier DSP slice among N_REQ requesters,
// with credit-based admission so every DSP result has a guaranteed FIFO slot.
module mcm_dsp_scheduler
  import mcm_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned X_W     = X_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned DSP_LAT = 1,
  parameter int unsigned FIFO_D  = DSP_LAT + 2,
  localparam int unsigned ID_W   = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*X_W-1:0]   req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic [X_W-1:0]         dsp_x,
  output logic [ID_W-1:0]        dsp_sel,
  output logic                   dsp_vld,
  input  logic [OUT_W-1:0]       dsp_p,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [OUT_W-1:0]       res_data,
  input  logic                   res_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_D + 1);

  logic [ID_W-1:0]       last;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       idx;
  logic                  grant_any;
  logic                  has_credit;
  logic [CNT_W:0]        used;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty, fifo_push;
  logic [ID_W+OUT_W-1:0] fifo_dout;
  logic [DSP_LAT-1:0]    tag_vld;
  logic [ID_W-1:0]       tag_id [DSP_LAT];

  // Registered occupancy only: a pop this cycle frees its credit next cycle, which keeps
  // res_ready out of the req_ready path.
  assign used       = {1'b0, fifo_count} + {1'b0, inflight};
  assign has_credit = (used < (CNT_W+1)'(FIFO_D)) && !fifo_full;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = ID_W'((32'(last) + 32'(k)) % N_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    if (!has_credit || rst) grant_any = 1'b0;
    req_ready = grant_any ? (N_REQ'(1) << grant_id) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_x   <= '0;
      dsp_sel <= '0;
      dsp_vld <= 1'b0;
      last    <= ID_W'(N_REQ - 1);
    end else begin
      dsp_vld <= grant_any;
      if (grant_any) begin
        dsp_x   <= req_x[grant_id*X_W +: X_W];
        dsp_sel <= grant_id;
        last    <= grant_id;
      end
    end
  end

  // Tags travel alongside the DSP pipeline so the ID lines up with dsp_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < int'(DSP_LAT); k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= dsp_vld;
      tag_id[0]  <= dsp_sel;
      for (int k = 1; k < int'(DSP_LAT); k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  assign fifo_push = tag_vld[DSP_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({grant_any, fifo_push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  mcm_res_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (ID_W + OUT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({tag_id[DSP_LAT-1], dsp_p}),
    .pop       (res_ready & ~fifo_empty),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign res_valid = ~fifo_empty;
  assign res_id    = fifo_dout[ID_W+OUT_W-1:OUT_W];
  assign res_data  = fifo_dout[OUT_W-1:0];

endmodule
